// File: rtl/fetch_queue.sv
// fetch_queue: RV32I instruction-fetch stage.
// Owns the fetch PC, issues word-aligned requests to instruction memory,
// buffers in-order responses with their PCs and hands them to decode.
// A redirect flushes the queue and discards responses that are still in flight.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   imem_req_valid_o/_ready_i/_addr_o   request channel to instruction memory
//   imem_rsp_valid_i/_data_i            in-order responses, no backpressure
//   redirect_i, redirect_pc_i           flush and restart fetch
//   insn_valid_o/_ready_i               head-of-queue handshake to decode
//   insn_o, pc_o, opcode_o              head instruction, its PC, insn_o[6:0]
//
// state    | meaning
// ST_RUN   | normal fetch; responses are pushed into the queue
// ST_DRAIN | waiting for stale responses after a redirect; no requests issued
module fetch_queue #(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [6:0]        opcode_o
);

  localparam int unsigned       CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned       PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DWIDTH-1:0] NOP   = DWIDTH'(32'h0000_0013);

  typedef enum logic {ST_RUN, ST_DRAIN} state_e;

  state_e            state_q;
  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] q_data_q [DEPTH];
  logic [AWIDTH-1:0] q_pc_q   [DEPTH];
  logic [PTR_W-1:0]  q_head_q, q_tail_q;
  logic [CNT_W-1:0]  q_cnt_q;
  logic [AWIDTH-1:0] if_pc_q  [DEPTH];
  logic [PTR_W-1:0]  if_head_q, if_tail_q;
  logic [CNT_W-1:0]  outstanding_q, drop_cnt_q, drop_cnt_d;
  logic [CNT_W:0]    occ;
  logic              req_fire, rsp_take, insn_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Queue entries plus in-flight requests form the credit pool that keeps
  // the queue from ever overflowing.
  assign occ              = {1'b0, q_cnt_q} + {1'b0, outstanding_q};
  assign imem_req_valid_o = !reset && !redirect_i && (state_q == ST_RUN) &&
                            (occ < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_take         = imem_rsp_valid_i && !redirect_i &&
                            (state_q == ST_RUN) && (drop_cnt_q == '0);

  assign insn_valid_o = !reset && (q_cnt_q != '0);
  assign insn_fire    = insn_valid_o && insn_ready_i && !redirect_i;
  assign insn_o       = insn_valid_o ? q_data_q[q_head_q] : NOP;
  assign pc_o         = insn_valid_o ? q_pc_q[q_head_q] : '0;
  assign opcode_o     = insn_o[6:0];

  // A response landing in the redirect cycle is itself discarded, so it
  // no longer counts towards the responses still to be dropped.
  assign drop_cnt_d = outstanding_q - CNT_W'(imem_rsp_valid_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= BASEADDR;
      q_head_q      <= '0;
      q_tail_q      <= '0;
      q_cnt_q       <= '0;
      if_head_q     <= '0;
      if_tail_q     <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data_q[i] <= NOP;
        q_pc_q[i]   <= '0;
        if_pc_q[i]  <= '0;
      end
    end else if (redirect_i) begin
      pc_q          <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      q_head_q      <= '0;
      q_tail_q      <= '0;
      q_cnt_q       <= '0;
      if_head_q     <= '0;
      if_tail_q     <= '0;
      drop_cnt_q    <= drop_cnt_d;
      outstanding_q <= drop_cnt_d;
      state_q       <= (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      if (req_fire) begin
        pc_q               <= pc_q + AWIDTH'(4);
        if_pc_q[if_tail_q] <= pc_q;
        if_tail_q          <= ptr_inc(if_tail_q);
      end
      if (rsp_take) begin
        q_data_q[q_tail_q] <= imem_rsp_data_i;
        q_pc_q[q_tail_q]   <= if_pc_q[if_head_q];
        q_tail_q           <= ptr_inc(q_tail_q);
        if_head_q          <= ptr_inc(if_head_q);
      end
      if (insn_fire) begin
        q_head_q <= ptr_inc(q_head_q);
      end
      if (rsp_take && !insn_fire) begin
        q_cnt_q <= q_cnt_q + 1'b1;
      end else if (!rsp_take && insn_fire) begin
        q_cnt_q <= q_cnt_q - 1'b1;
      end
      if (req_fire && !imem_rsp_valid_i) begin
        outstanding_q <= outstanding_q + 1'b1;
      end else if (!req_fire && imem_rsp_valid_i) begin
        outstanding_q <= outstanding_q - 1'b1;
      end
      if ((state_q == ST_DRAIN) && imem_rsp_valid_i) begin
        drop_cnt_q <= drop_cnt_q - 1'b1;
        if (drop_cnt_q == CNT_W'(1)) begin
          state_q <= ST_RUN;
        end
      end
    end
  end

  a_rsp_credit: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid_i |-> (outstanding_q != '0));

  a_occ_bound: assert property (@(posedge clk) disable iff (reset)
    occ <= (CNT_W + 1)'(DEPTH));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b1;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        insn_valid_o;
  logic        insn_ready_i = 1'b0;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;

  fetch_queue dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .insn_valid_o     (insn_valid_o),
    .insn_ready_i     (insn_ready_i),
    .insn_o           (insn_o),
    .pc_o             (pc_o),
    .opcode_o         (opcode_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          req_cnt = 0;
  bit          req_toggle = 1'b0;
  logic [31:0] exp_req_addr = BASE;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {~a[31:16], a[17:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.insn = memdata(pc);
    exp_q.push_back(e);
  endtask

  // Instruction memory: in-order responses after a fixed latency; also checks
  // the request address sequence and address stability while stalled.
  always begin
    @(negedge clk);
    cyc++;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = memdata(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
    end
    #4;
    if (reset) begin
      pend_q.delete();
      prev_stall = 1'b0;
    end else if (imem_req_valid_o) begin
      if (prev_stall) check("req_addr_stable", imem_req_addr_o, prev_addr);
      if (imem_req_ready_i) begin
        pend_t p;
        check("req_addr_seq", imem_req_addr_o, exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        p.addr = imem_req_addr_o;
        p.due  = cyc + lat;
        pend_q.push_back(p);
        req_cnt++;
      end
      prev_stall = !imem_req_ready_i;
      prev_addr  = imem_req_addr_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Decode-side monitor: every accepted instruction is checked against the
  // scoreboard; a pop in a redirect cycle is discarded by the design.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (!reset && insn_valid_o && insn_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dec_unexpected: pc %h insn %h presented, none expected", pc_o, insn_o);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", pc_o, e.pc);
        check("dec_insn", insn_o, e.insn);
        check("dec_opcode", 32'(opcode_o), 32'(e.insn[6:0]));
      end
    end
  end

  task automatic cyc_begin();
    @(negedge clk);
    reset        = 1'b0;
    redirect_i   = 1'b0;
    insn_ready_i = (exp_q.size() != 0);
    if (req_toggle) imem_req_ready_i = !imem_req_ready_i;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      reset        = 1'b1;
      insn_ready_i = 1'b0;
      exp_q.delete();
      exp_req_addr = BASE;
      #4;
      check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
      check("rst_insn_valid", 32'(insn_valid_o), 32'd0);
      check("rst_insn", insn_o, NOP);
      check("rst_pc", pc_o, 32'd0);
    end
    req_cnt = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cyc_begin();
      #4;
      k++;
    end
    check({"drain_", name}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: free-running fetch, latency 1
    lat = 1;
    do_reset(3);
    for (int i = 0; i < 8; i++) exp_push(BASE + 32'(4 * i));
    drain("stream", 60);

    // 2: decode stalled for 10 cycles, then both entries drain in order
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      #4;
    end
    check("stall_req_cnt", 32'(req_cnt), 32'd2);
    check("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("stall_insn_valid", 32'(insn_valid_o), 32'd1);
    check("stall_head_pc", pc_o, BASE);
    for (int i = 0; i < 4; i++) exp_push(BASE + 32'(4 * i));
    drain("after_stall", 40);

    // 3: request ready toggling 1,0,1,0
    do_reset(2);
    imem_req_ready_i = 1'b0;
    req_toggle = 1'b1;
    for (int i = 0; i < 6; i++) exp_push(BASE + 32'(4 * i));
    drain("toggle", 80);
    req_toggle = 1'b0;
    imem_req_ready_i = 1'b1;

    // 4: latency 3, redirect with two requests in flight
    lat = 3;
    do_reset(2);
    cyc_begin(); #4;
    cyc_begin(); #4;
    cyc_begin();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0100_0103;
    exp_req_addr  = 32'h0100_0100;
    #4;
    check("redir_req_suppressed", 32'(imem_req_valid_o), 32'd0);
    exp_push(32'h0100_0100);
    exp_push(32'h0100_0104);
    cyc_begin(); #4;
    check("drain1_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("drain1_insn_valid", 32'(insn_valid_o), 32'd0);
    cyc_begin(); #4;
    check("drain2_req_valid", 32'(imem_req_valid_o), 32'd0);
    cyc_begin(); #4;
    check("post_drain_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("post_drain_req_addr", imem_req_addr_o, 32'h0100_0100);
    drain("redirect", 40);

    // 5a: latency 2, redirect with queue occupied, decode pop and response in same cycle
    lat = 2;
    do_reset(2);
    cyc_begin(); #4;
    cyc_begin(); #4;
    cyc_begin(); #4;
    cyc_begin();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0200_0008;
    insn_ready_i  = 1'b1;
    exp_req_addr  = 32'h0200_0008;
    #4;
    check("flush_pre_insn_valid", 32'(insn_valid_o), 32'd1);
    check("flush_pre_pc", pc_o, BASE);
    check("flush_pre_rsp", 32'(imem_rsp_valid_i), 32'd1);
    exp_push(32'h0200_0008);
    exp_push(32'h0200_000C);
    cyc_begin(); #4;
    check("flush_queue_empty", 32'(insn_valid_o), 32'd0);
    check("flush_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("flush_req_addr", imem_req_addr_o, 32'h0200_0008);
    drain("flush", 40);

    // 5b: latency 3, redirect while a response arrives with two outstanding
    lat = 3;
    do_reset(2);
    cyc_begin(); #4;
    cyc_begin(); #4;
    cyc_begin(); #4;
    cyc_begin();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0FFE;
    exp_req_addr  = 32'h0000_0FFC;
    #4;
    check("drop1_redir_req", 32'(imem_req_valid_o), 32'd0);
    exp_push(32'h0000_0FFC);
    exp_push(32'h0000_1000);
    cyc_begin(); #4;
    check("drop1_drain_req", 32'(imem_req_valid_o), 32'd0);
    cyc_begin(); #4;
    check("drop1_run_req", 32'(imem_req_valid_o), 32'd1);
    check("drop1_run_addr", imem_req_addr_o, 32'h0000_0FFC);
    drain("drop1", 40);

    // 6: one-cycle reset mid-operation
    lat = 3;
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      cyc_begin(); #4;
    end
    cyc_begin();
    reset = 1'b1;
    exp_req_addr = BASE;
    #4;
    check("midrst_req_valid", 32'(imem_req_valid_o), 32'd0);
    check("midrst_insn_valid", 32'(insn_valid_o), 32'd0);
    check("midrst_insn", insn_o, NOP);
    check("midrst_pc", pc_o, 32'd0);
    cyc_begin(); #4;
    check("postrst_insn_valid", 32'(insn_valid_o), 32'd0);
    check("postrst_insn", insn_o, NOP);
    check("postrst_pc", pc_o, 32'd0);
    check("postrst_req_valid", 32'(imem_req_valid_o), 32'd1);
    check("postrst_req_addr", imem_req_addr_o, BASE);
    exp_push(BASE);
    exp_push(BASE + 32'd4);
    drain("postrst", 40);

    repeat (3) cyc_begin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
